// File: rtl/door_cycle_scheduler.sv
// Door actuator sequencer: call-point arbitration, open/hold/close cycle, fault latch.
// Define DOOR_SCHED_RR_EN for round-robin arbitration (fixed priority otherwise).
module door_cycle_scheduler #(
  parameter int HOLD_CYCLES   = 16,
  parameter int MOTOR_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       lim_open,
  input  logic       lim_closed,
  input  logic       obstruct,
  input  logic       clr_fault,
  output logic       motor_open,
  output logic       motor_close,
  output logic [3:0] grant,
  output logic [2:0] state,
  output logic       fault
);

  localparam int TW = $clog2(MOTOR_TIMEOUT) + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_OPENING = 3'd1,
    ST_HOLD    = 3'd2,
    ST_CLOSING = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    pending_q, pending_d;
  logic [3:0]    grant_q, grant_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    cand, win;
  logic          timeout;

  assign cand = pending_q | req;

`ifdef DOOR_SCHED_RR_EN
  logic [1:0] ptr_q;
  logic [1:0] win_idx;
  logic [1:0] rr_idx;

  // Scan offsets 4..1 so the nearest index after the pointer is written last.
  always_comb begin
    win     = '0;
    win_idx = '0;
    rr_idx  = '0;
    for (int unsigned i = 4; i >= 1; i--) begin
      rr_idx = ptr_q + 2'(i);
      if (cand[rr_idx]) begin
        win     = 4'b0001 << rr_idx;
        win_idx = rr_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr_q <= 2'd3;
    else if (state_q == ST_CLOSED && state_d == ST_OPENING)
      ptr_q <= win_idx;
  end
`else
  // Isolate the lowest set bit.
  assign win = cand & (~cand + 4'd1);
`endif

  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TW'(1);
  assign timeout   = (timer_inc == TW'(MOTOR_TIMEOUT));

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | req;
    grant_d   = grant_q;
    timer_d   = timer_inc;
    hold_d    = hold_q;
    if (state_q != ST_FAULT && lim_open && lim_closed) begin
      state_d = ST_FAULT;
      grant_d = '0;
    end else begin
      case (state_q)
        ST_CLOSED: begin
          timer_d = '0;
          if (|cand) begin
            state_d   = ST_OPENING;
            grant_d   = win;
            pending_d = cand & ~win;
          end
        end
        ST_OPENING: begin
          if (lim_open) begin
            state_d = ST_HOLD;
            hold_d  = HW'(HOLD_CYCLES - 1);
          end else if (timeout) begin
            state_d = ST_FAULT;
            grant_d = '0;
          end
        end
        ST_HOLD: begin
          // Requests arriving while open are served by this cycle, not queued.
          pending_d = pending_q & ~req;
          if (|req) begin
            hold_d = HW'(HOLD_CYCLES - 1);
          end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
          end else if (!obstruct) begin
            state_d = ST_CLOSING;
            timer_d = '0;
          end
        end
        ST_CLOSING: begin
          if (obstruct) begin
            state_d = ST_OPENING;
            timer_d = '0;
          end else if (lim_closed) begin
            state_d = ST_CLOSED;
            grant_d = '0;
          end else if (timeout) begin
            state_d = ST_FAULT;
            grant_d = '0;
          end
        end
        ST_FAULT: begin
          grant_d = '0;
          if (clr_fault) begin
            if (lim_closed) begin
              state_d = ST_CLOSED;
            end else begin
              state_d = ST_CLOSING;
              timer_d = '0;
            end
          end
        end
        default: begin
          state_d = ST_FAULT;
          grant_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLOSED;
      pending_q <= '0;
      grant_q   <= '0;
      timer_q   <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
    end
  end

  assign state       = state_q;
  assign grant       = grant_q;
  assign motor_open  = (state_q == ST_OPENING);
  assign motor_close = (state_q == ST_CLOSING);
  assign fault       = (state_q == ST_FAULT);

endmodule

// File: doc/door_cycle_scheduler.md
# door_cycle_scheduler

Sequences the door actuator behind the door FSM. It arbitrates open requests from four call points, drives the open/close motor through a full door cycle using limit switches, a hold timer and an obstruction input, and latches a fault on motor timeout or inconsistent sensors. It sits between the call-point/sensor inputs and the motor driver pins of the door tile.

## Interface
- `HOLD_CYCLES`, default 16: cycles the door stays open after reaching `lim_open`.
- `MOTOR_TIMEOUT`, default 64: maximum cycles allowed in OPENING or CLOSING before a fault.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 4: level open requests, one per call point; index 0 is the highest fixed priority.
- `lim_open` in 1: door fully open.
- `lim_closed` in 1: door fully closed.
- `obstruct` in 1: obstruction present in the doorway.
- `clr_fault` in 1: acknowledge fault, single-cycle pulse.
- `motor_open` out 1: drive door open.
- `motor_close` out 1: drive door closed.
- `grant` out 4: one-hot, the call point being served.
- `state` out 3: CLOSED=0, OPENING=1, HOLD=2, CLOSING=3, FAULT=4.
- `fault` out 1: high in FAULT.

## Operation
- `pending[3:0]` is a sticky register.
  - Set by `req`.
  - The granted bit is cleared on the grant edge.
  - In HOLD, any bit set by `req` is cleared on the next edge (served by the open door) and reloads the hold counter.
- CLOSED: if `pending|req` is nonzero, select a winner, set `grant`, clear the motor timer, go to OPENING.
- OPENING:
  - `lim_open` → HOLD, loading the hold counter with `HOLD_CYCLES-1`.
  - Timer reaching `MOTOR_TIMEOUT` → FAULT.
- HOLD:
  - The counter decrements to 0.
  - When the counter is 0 and `obstruct`=0 → CLOSING, clearing the timer.
  - When the counter is 0 and `obstruct`=1, stay in HOLD with the counter at 0.
- CLOSING:
  - `obstruct`=1 → OPENING, clearing the timer; reopen has priority over `lim_closed`.
  - Otherwise `lim_closed` → CLOSED, and `grant` clears to 0.
  - Timer reaching `MOTOR_TIMEOUT` → FAULT.
- FAULT:
  - Both motors off, `grant`=0, `pending` retained.
  - `clr_fault` → CLOSED if `lim_closed`=1, else CLOSING with the timer cleared.
- Both `lim_open` and `lim_closed` high in any non-FAULT state → FAULT on that edge. This has priority over every other transition.
- Outputs are Moore, decoded from registered state only:
  - `motor_open` = (state==OPENING).
  - `motor_close` = (state==CLOSING).
  - `motor_open` and `motor_close` are never both 1.
- Motor timer is $clog2(`MOTOR_TIMEOUT`)+1 bits wide and saturates. Hold counter is $clog2(`HOLD_CYCLES`) bits wide.

## Timing
- Reset values:
  - `state`=CLOSED.
  - `motor_open`=0, `motor_close`=0, `grant`=0, `fault`=0.
  - `pending`=0, timers=0, round-robin pointer=3.
- Latency:
  - `req` sampled high at edge k → `state`=OPENING, `motor_open`=1 and `grant` valid after edge k.
  - `lim_open` high at edge k → HOLD after edge k.
  - CLOSING begins `HOLD_CYCLES` edges after HOLD entry when there is no obstruction or new request.
- Timeout: FAULT is entered on the edge where the timer equals `MOTOR_TIMEOUT`, i.e. `MOTOR_TIMEOUT` cycles after entering the motion state.
- Simultaneous `req` and `clr_fault` in FAULT: the request stays pending and is served on return to CLOSED.
- `rst_n` low mid-cycle forces reset values asynchronously, including motors off.

## Configuration
- `DOOR_SCHED_RR_EN` defined:
  - Round-robin arbitration.
  - The winner is the first pending index after the last granted index, wrapping 3→0.
  - The pointer updates on each grant.
- Not defined:
  - Fixed priority, lowest set index wins.
  - No pointer register.

## Test plan
- Reset with `req`=0 → `state`=0, all outputs 0. Pulse `req`=4'b0100 → next cycle `state`=1, `motor_open`=1, `grant`=4'b0100.
- Full cycle, `HOLD_CYCLES`=16:
  - Assert `lim_open` → HOLD.
  - Exactly 16 cycles later `state`=3 and `motor_close`=1.
  - `lim_closed` → `state`=0, `grant`=0.
- `obstruct` pulsed during CLOSING → `state`=1 next cycle. Also hold `obstruct` when the HOLD counter expires → remains HOLD until `obstruct`=0.
- OPENING with no `lim_open` for 64 cycles → `fault`=1, motors 0. Then `clr_fault` with `lim_closed`=0 → `state`=3.
- `req`=4'b1111 served repeatedly:
  - With `DOOR_SCHED_RR_EN`, grants are 0001, 0010, 0100, 1000.
  - Without it, grants are 0001, then 0010, and so on as lower bits are cleared.
- Error and reset cases:
  - `lim_open`=`lim_closed`=1 in HOLD → FAULT next edge.
  - `rst_n` dropped during OPENING → `motor_open`=0 immediately, without waiting for a clock edge.
